ex_unit: RTL and testbench

Parametrised execute stage for the 5-stage pipeline, placed between ID/EX and EX/MEM. Computes the ALU result from register/PC/immediate operands, generates load/store byte-lane masks, store-data lane alignment and misalignment flags, and holds everything in a registered EX/MEM output slot with a valid/ready handshake. Optionally includes an iterative multiply/divide unit that stalls the stage for a fixed number of cycles.

---
 rtl/ex_pkg.sv | 52 +++++
 rtl/ex_muldiv_iter.sv | 124 ++++++++++++
 rtl/ex_unit.sv | 263 ++++++++++++++++++++++++++
 tb/tb_ex_unit.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_pkg.sv
// ex_pkg: shared encodings for the execute stage.
// ALU operation codes, memory access sizes, M-extension funct3 codes and the
// multiply/divide sequencer state type used when EX_MULDIV_EN is defined.
package ex_pkg;

    // ALU operation select (codes 12-15 are reserved and pass operand a)
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_B    = 4'd2;
    localparam logic [3:0] ALU_SLL  = 4'd3;
    localparam logic [3:0] ALU_SRL  = 4'd4;
    localparam logic [3:0] ALU_AND  = 4'd5;
    localparam logic [3:0] ALU_OR   = 4'd6;
    localparam logic [3:0] ALU_XOR  = 4'd7;
    localparam logic [3:0] ALU_A    = 4'd8;
    localparam logic [3:0] ALU_SLT  = 4'd9;
    localparam logic [3:0] ALU_SRA  = 4'd10;
    localparam logic [3:0] ALU_SLTU = 4'd11;

    // Memory access size, funct3[1:0]
    localparam logic [1:0] MEM_B = 2'd0;
    localparam logic [1:0] MEM_H = 2'd1;
    localparam logic [1:0] MEM_W = 2'd2;
    localparam logic [1:0] MEM_D = 2'd3;

    // M-extension operations, funct3
    localparam logic [2:0] M_MUL    = 3'd0;
    localparam logic [2:0] M_MULH   = 3'd1;
    localparam logic [2:0] M_MULHSU = 3'd2;
    localparam logic [2:0] M_MULHU  = 3'd3;
    localparam logic [2:0] M_DIV    = 3'd4;
    localparam logic [2:0] M_DIVU   = 3'd5;
    localparam logic [2:0] M_REM    = 3'd6;
    localparam logic [2:0] M_REMU   = 3'd7;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} md_state_t;

    // Number of bytes touched by an access of the given size
    function automatic logic [3:0] size_bytes(input logic [1:0] size);
        logic [3:0] n;
        n = 4'd1;
        case (size)
            MEM_B: n = 4'd1;
            MEM_H: n = 4'd2;
            MEM_W: n = 4'd4;
            MEM_D: n = 4'd8;
            default: n = 4'd1;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/ex_muldiv_iter.sv
// ex_muldiv_iter: iterative shift-add multiplier / restoring divider.
// i_start latches operands; exactly XLEN step cycles follow. o_done is high
// during the cycle whose clock edge performs the final step, so o_result is
// final from the edge after o_done and holds until the next i_start.
// Signed operands are converted to magnitudes up front and the sign is
// re-applied on the way out; divide-by-zero is resolved at the output mux so
// the latency does not depend on the operands.
module ex_muldiv_iter
    import ex_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_start,
    input  logic [2:0]      i_funct3,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic            o_done,
    output logic [XLEN-1:0] o_result
);

    localparam int CW = $clog2(XLEN);

    logic            r_run;
    logic [CW-1:0]   r_cnt;
    logic [2:0]      r_f3;
    logic [XLEN-1:0] r_a;
    logic [XLEN-1:0] r_b;
    logic [XLEN-1:0] r_mc;     // multiplicand / divisor magnitude
    logic [XLEN-1:0] r_acc;    // product high half / partial remainder
    logic [XLEN-1:0] r_lo;     // multiplier -> product low half / dividend -> quotient
    logic            r_neg_res;
    logic            r_neg_rem;

    logic            w_sa;
    logic            w_sb;
    logic            w_a_neg;
    logic            w_b_neg;
    logic [XLEN:0]   w_sum;
    logic [XLEN:0]   w_shift;
    logic [XLEN:0]   w_diff;
    logic [2*XLEN-1:0] w_prod;
    logic [2*XLEN-1:0] w_prod_s;
    logic [XLEN-1:0] w_quo;
    logic [XLEN-1:0] w_rem;
    logic            w_b_zero;

    assign w_sa    = (i_funct3 == M_MULH) || (i_funct3 == M_MULHSU) ||
                     (i_funct3 == M_DIV)  || (i_funct3 == M_REM);
    assign w_sb    = (i_funct3 == M_MULH) || (i_funct3 == M_DIV) || (i_funct3 == M_REM);
    assign w_a_neg = w_sa && i_a[XLEN-1];
    assign w_b_neg = w_sb && i_b[XLEN-1];

    // One multiply step (conditional add then shift) and one divide step
    assign w_sum   = {1'b0, r_acc} + (r_lo[0] ? {1'b0, r_mc} : {(XLEN+1){1'b0}});
    assign w_shift = {r_acc, r_lo[XLEN-1]};
    assign w_diff  = w_shift - {1'b0, r_mc};

    assign o_done  = r_run && (r_cnt == CW'(XLEN-1));

    // Operand capture on start, then one iteration per cycle until done
    always_ff @(posedge clk) begin
        if (rst) begin
            r_run     <= 1'b0;
            r_cnt     <= '0;
            r_f3      <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_mc      <= '0;
            r_acc     <= '0;
            r_lo      <= '0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
        end else if (i_start) begin
            r_run     <= 1'b1;
            r_cnt     <= '0;
            r_f3      <= i_funct3;
            r_a       <= i_a;
            r_b       <= i_b;
            r_mc      <= w_b_neg ? -i_b : i_b;
            r_lo      <= w_a_neg ? -i_a : i_a;
            r_acc     <= '0;
            r_neg_res <= w_a_neg ^ w_b_neg;
            r_neg_rem <= w_a_neg;
        end else if (r_run) begin
            r_cnt <= r_cnt + 1'b1;
            if (o_done) begin
                r_run <= 1'b0;
            end
            if (r_f3[2]) begin
                if (!w_diff[XLEN]) begin
                    r_acc <= w_diff[XLEN-1:0];
                    r_lo  <= {r_lo[XLEN-2:0], 1'b1};
                end else begin
                    r_acc <= w_shift[XLEN-1:0];
                    r_lo  <= {r_lo[XLEN-2:0], 1'b0};
                end
            end else begin
                r_acc <= w_sum[XLEN:1];
                r_lo  <= {w_sum[0], r_lo[XLEN-1:1]};
            end
        end
    end

    assign w_prod   = {r_acc, r_lo};
    assign w_prod_s = r_neg_res ? -w_prod : w_prod;
    assign w_quo    = r_neg_res ? -r_lo : r_lo;
    assign w_rem    = r_neg_rem ? -r_acc : r_acc;
    assign w_b_zero = (r_b == '0);

    // Result selection with sign restore and divide-by-zero override
    always_comb begin
        o_result = w_prod_s[XLEN-1:0];
        case (r_f3)
            M_MUL:                    o_result = w_prod_s[XLEN-1:0];
            M_MULH, M_MULHSU, M_MULHU: o_result = w_prod_s[2*XLEN-1:XLEN];
            M_DIV, M_DIVU:            o_result = w_b_zero ? {XLEN{1'b1}} : w_quo;
            M_REM, M_REMU:            o_result = w_b_zero ? r_a : w_rem;
            default:                  o_result = w_prod_s[XLEN-1:0];
        endcase
    end

endmodule

// File: rtl/ex_unit.sv
// ex_unit: execute stage between ID/EX and EX/MEM.
// ALU, load/store lane mask and store alignment, registered output slot with
// valid/ready handshake. Defining EX_MULDIV_EN adds the iterative M-extension
// unit and its sequencer; without it md_sel is ignored and busy is 0.
module ex_unit
    import ex_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   pc,
    input  logic [XLEN-1:0]   imm,
    input  logic [XLEN-1:0]   rd1,
    input  logic [XLEN-1:0]   rd2,
    input  logic              a_pc_sel,
    input  logic              b_imm_sel,
    input  logic [3:0]        alu_sel,
    input  logic [2:0]        funct3,
    input  logic              loadSel,
    input  logic              storeSel,
    input  logic              md_sel,
    input  logic              we,
    input  logic [4:0]        wa,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   alu,
    output logic [XLEN-1:0]   store_data,
    output logic [XLEN/8-1:0] mask,
    output logic              sign_ext,
    output logic              misalign,
    output logic              we_out,
    output logic [4:0]        wa_out,
    output logic              load_out,
    output logic              store_out,
    output logic              busy
);

    localparam int NB  = XLEN / 8;
    localparam int SHW = $clog2(XLEN);
    localparam int OFW = $clog2(NB);

    logic              r_out_valid;
    logic [XLEN-1:0]   r_alu;
    logic [XLEN-1:0]   r_store_data;
    logic [NB-1:0]     r_mask;
    logic              r_sign_ext;
    logic              r_misalign;
    logic              r_we;
    logic [4:0]        r_wa;
    logic              r_load;
    logic              r_store;

    logic [XLEN-1:0]   w_a;
    logic [XLEN-1:0]   w_b;
    logic [SHW-1:0]    w_shamt;
    logic [XLEN-1:0]   w_alu;
    logic [OFW-1:0]    w_offset;
    logic [3:0]        w_bytes;
    logic              w_mis_raw;
    logic [15:0]       w_mask_wide;
    logic [NB-1:0]     w_mask;
    logic              w_sext;
    logic              w_mis;
    logic [XLEN-1:0]   w_sdata;
    logic              w_busy;
    logic              w_accept;
    logic              w_acc_alu;
    logic              w_md_load;
    logic [XLEN-1:0]   w_md_result;
    logic              w_md_we;
    logic [4:0]        w_md_wa;
    logic [XLEN-1:0]   w_md_rd2;

    assign w_a     = a_pc_sel  ? pc  : rd1;
    assign w_b     = b_imm_sel ? imm : rd2;
    assign w_shamt = w_b[SHW-1:0];

    // ALU result / effective address
    always_comb begin
        w_alu = w_a;
        case (alu_sel)
            ALU_ADD:  w_alu = w_a + w_b;
            ALU_SUB:  w_alu = w_a - w_b;
            ALU_B:    w_alu = w_b;
            ALU_SLL:  w_alu = w_a << w_shamt;
            ALU_SRL:  w_alu = w_a >> w_shamt;
            ALU_AND:  w_alu = w_a & w_b;
            ALU_OR:   w_alu = w_a | w_b;
            ALU_XOR:  w_alu = w_a ^ w_b;
            ALU_A:    w_alu = w_a;
            ALU_SLT:  w_alu = {{(XLEN-1){1'b0}}, ($signed(w_a) < $signed(w_b))};
            ALU_SRA:  w_alu = $signed(w_a) >>> w_shamt;
            ALU_SLTU: w_alu = {{(XLEN-1){1'b0}}, (w_a < w_b)};
            default:  w_alu = w_a;
        endcase
    end

    assign w_offset    = w_alu[OFW-1:0];
    assign w_bytes     = size_bytes(funct3[1:0]);
    assign w_mis_raw   = ((4'(w_offset) & (w_bytes - 4'd1)) != 4'd0) ||
                         (32'(w_bytes) > 32'(NB));
    assign w_mask_wide = ((16'd1 << w_bytes) - 16'd1) << w_offset;

    // Byte-lane mask, load sign handling and store-data alignment
    always_comb begin
        w_mask  = '0;
        w_sext  = 1'b0;
        w_mis   = 1'b0;
        w_sdata = rd2;
        if (loadSel || storeSel) begin
            w_mis = w_mis_raw;
            if (!w_mis_raw) begin
                w_mask = w_mask_wide[NB-1:0];
            end
            if (loadSel) begin
                w_sext = !funct3[2];
            end
            if (storeSel) begin
                w_sdata = rd2 << {w_offset, 3'b000};
            end
        end
    end

    assign in_ready = !w_busy && (!r_out_valid || out_ready);
    assign w_accept = in_valid && in_ready;

`ifdef EX_MULDIV_EN
    md_state_t       r_state;
    logic            r_busy;
    logic            r_md_we;
    logic [4:0]      r_md_wa;
    logic [XLEN-1:0] r_md_rd2;
    logic            w_md_start;
    logic            w_md_done;

    assign w_md_start = w_accept && md_sel;
    assign w_acc_alu  = w_accept && !md_sel;

    ex_muldiv_iter #(
        .XLEN(XLEN)
    ) u_muldiv (
        .clk      (clk),
        .rst      (rst),
        .i_start  (w_md_start),
        .i_funct3 (funct3),
        .i_a      (w_a),
        .i_b      (w_b),
        .o_done   (w_md_done),
        .o_result (w_md_result)
    );

    // Sequencer: stall the stage from accept until the result enters the slot
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_busy   <= 1'b0;
            r_md_we  <= 1'b0;
            r_md_wa  <= '0;
            r_md_rd2 <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_md_start) begin
                        r_state  <= S_RUN;
                        r_busy   <= 1'b1;
                        r_md_we  <= we;
                        r_md_wa  <= wa;
                        r_md_rd2 <= rd2;
                    end
                end
                S_RUN: begin
                    if (w_md_done) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (!r_out_valid || out_ready) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign w_busy    = r_busy;
    assign w_md_load = (r_state == S_DONE) && (!r_out_valid || out_ready);
    assign w_md_we   = r_md_we;
    assign w_md_wa   = r_md_wa;
    assign w_md_rd2  = r_md_rd2;
`else
    logic w_unused_md;

    assign w_unused_md = md_sel;
    assign w_acc_alu   = w_accept;
    assign w_busy      = 1'b0;
    assign w_md_load   = 1'b0;
    assign w_md_result = '0;
    assign w_md_we     = 1'b0;
    assign w_md_wa     = '0;
    assign w_md_rd2    = '0;
`endif

    // EX/MEM output slot: load on transfer, hold under backpressure, drop when consumed
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_alu        <= '0;
            r_store_data <= '0;
            r_mask       <= '0;
            r_sign_ext   <= 1'b0;
            r_misalign   <= 1'b0;
            r_we         <= 1'b0;
            r_wa         <= '0;
            r_load       <= 1'b0;
            r_store      <= 1'b0;
        end else if (w_acc_alu) begin
            r_out_valid  <= 1'b1;
            r_alu        <= w_alu;
            r_store_data <= w_sdata;
            r_mask       <= w_mask;
            r_sign_ext   <= w_sext;
            r_misalign   <= w_mis;
            r_we         <= we && !w_mis;
            r_wa         <= wa;
            r_load       <= loadSel;
            r_store      <= storeSel;
        end else if (w_md_load) begin
            r_out_valid  <= 1'b1;
            r_alu        <= w_md_result;
            r_store_data <= w_md_rd2;
            r_mask       <= '0;
            r_sign_ext   <= 1'b0;
            r_misalign   <= 1'b0;
            r_we         <= w_md_we;
            r_wa         <= w_md_wa;
            r_load       <= 1'b0;
            r_store      <= 1'b0;
        end else if (out_ready) begin
            r_out_valid  <= 1'b0;
        end
    end

    assign out_valid  = r_out_valid;
    assign alu        = r_alu;
    assign store_data = r_store_data;
    assign mask       = r_mask;
    assign sign_ext   = r_sign_ext;
    assign misalign   = r_misalign;
    assign we_out     = r_we;
    assign wa_out     = r_wa;
    assign load_out   = r_load;
    assign store_out  = r_store;
    assign busy       = w_busy;

endmodule

// File: tb/tb_ex_unit.sv
// tb_ex_unit: directed self-checking bench for ex_unit (XLEN=32).
// Multiply/divide checks are compiled only when EX_MULDIV_EN is defined.
module tb_ex_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic        a_pc_sel;
    logic        b_imm_sel;
    logic [3:0]  alu_sel;
    logic [2:0]  funct3;
    logic        loadSel;
    logic        storeSel;
    logic        md_sel;
    logic        we;
    logic [4:0]  wa;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] alu;
    logic [31:0] store_data;
    logic [3:0]  mask;
    logic        sign_ext;
    logic        misalign;
    logic        we_out;
    logic [4:0]  wa_out;
    logic        load_out;
    logic        store_out;
    logic        busy;

    int checks = 0;
    int errors = 0;

    ex_unit #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .pc(pc), .imm(imm), .rd1(rd1), .rd2(rd2),
        .a_pc_sel(a_pc_sel), .b_imm_sel(b_imm_sel), .alu_sel(alu_sel),
        .funct3(funct3), .loadSel(loadSel), .storeSel(storeSel), .md_sel(md_sel),
        .we(we), .wa(wa), .out_valid(out_valid), .out_ready(out_ready),
        .alu(alu), .store_data(store_data), .mask(mask), .sign_ext(sign_ext),
        .misalign(misalign), .we_out(we_out), .wa_out(wa_out),
        .load_out(load_out), .store_out(store_out), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "simulation did not finish");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b);
        in_valid  = 1'b1;
        rd1       = a;
        rd2       = b;
        alu_sel   = sel;
        a_pc_sel  = 1'b0;
        b_imm_sel = 1'b0;
        loadSel   = 1'b0;
        storeSel  = 1'b0;
        md_sel    = 1'b0;
    endtask

    task automatic alu_chk(input string tag, input logic [3:0] sel,
                           input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
        set_op(sel, a, b);
        tick();
        chk(tag, alu, exp);
        $display("alu   %-6s a=%08h b=%08h -> %08h", tag, a, b, alu);
    endtask

    task automatic mem_op(input logic is_load, input logic [2:0] f3,
                          input logic [31:0] base, input logic [31:0] off, input logic [31:0] data);
        set_op(4'd0, base, data);
        imm       = off;
        b_imm_sel = 1'b1;
        funct3    = f3;
        loadSel   = is_load;
        storeSel  = !is_load;
        we        = is_load;
        wa        = 5'd9;
        tick();
        $display("mem   %s f3=%0d addr=%08h mask=%b data=%08h mis=%b we=%b",
                 is_load ? "ld" : "st", f3, alu, mask, store_data, misalign, we_out);
    endtask

`ifdef EX_MULDIV_EN
    task automatic md_op(input string tag, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
        set_op(4'd0, a, b);
        md_sel = 1'b1;
        funct3 = f3;
        tick();
        in_valid = 1'b0;
        md_sel   = 1'b0;
        chk({tag, "_busy"}, busy, 1'b1);
        repeat (32) tick();
        chk({tag, "_early"}, out_valid, 1'b0);
        tick();
        chk({tag, "_valid"}, out_valid, 1'b1);
        chk(tag, alu, exp);
        chk({tag, "_idle"}, busy, 1'b0);
        $display("md    %-6s a=%08h b=%08h -> %08h", tag, a, b, alu);
        tick();
    endtask
`endif

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        pc = '0; imm = '0; rd1 = '0; rd2 = '0; a_pc_sel = 1'b0; b_imm_sel = 1'b0;
        alu_sel = '0; funct3 = '0; loadSel = 1'b0; storeSel = 1'b0; md_sel = 1'b0;
        we = 1'b0; wa = '0;

        // Reset state
        tick(); tick();
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_alu", alu, 32'h0);
        chk("rst_mask", mask, 4'h0);
        chk("rst_we", we_out, 1'b0);
        chk("rst_busy", busy, 1'b0);
        rst = 1'b0;
        tick();
        chk("rst_ready", in_ready, 1'b1);
        $display("reset valid=%b ready=%b busy=%b", out_valid, in_ready, busy);

        // 5 - 7 with writeback pass-through, one-cycle latency
        set_op(4'd1, 32'd5, 32'd7);
        we = 1'b1; wa = 5'd3;
        tick();
        chk("sub_valid", out_valid, 1'b1);
        chk("sub", alu, 32'hFFFF_FFFE);
        chk("sub_we", we_out, 1'b1);
        chk("sub_wa", wa_out, 5'd3);
        chk("sub_sdata", store_data, 32'd7);
        chk("sub_mask", mask, 4'h0);
        $display("alu   sub    -> %08h valid=%b", alu, out_valid);

        // Back-to-back ALU ops
        we = 1'b0;
        alu_chk("add",  4'd0,  32'h10,        32'h20,  32'h30);
        alu_chk("sll",  4'd3,  32'h1,         32'h24,  32'h10);
        alu_chk("srl",  4'd4,  32'h8000_0000, 32'h4,   32'h0800_0000);
        alu_chk("sra",  4'd10, 32'h8000_0000, 32'h4,   32'hF800_0000);
        alu_chk("and",  4'd5,  32'hF0F0,      32'hFF00, 32'hF000);
        alu_chk("or",   4'd6,  32'hF0F0,      32'hFF00, 32'hFFF0);
        alu_chk("xor",  4'd7,  32'hF0F0,      32'hFF00, 32'h0FF0);
        alu_chk("passb", 4'd2, 32'h11,        32'h22,  32'h22);
        alu_chk("passa", 4'd8, 32'h11,        32'h22,  32'h11);
        alu_chk("slt",  4'd9,  32'hFFFF_FFFF, 32'h1,   32'h1);
        alu_chk("sltu", 4'd11, 32'hFFFF_FFFF, 32'h1,   32'h0);
        alu_chk("rsvd", 4'd14, 32'h11,        32'h22,  32'h11);
        set_op(4'd0, 32'h0, 32'h0);
        pc = 32'h400; imm = 32'h8; a_pc_sel = 1'b1; b_imm_sel = 1'b1;
        tick();
        chk("pc_imm", alu, 32'h408);
        $display("alu   pc+imm -> %08h", alu);

        // Memory ops
        mem_op(1'b0, 3'b000, 32'h1000, 32'h3, 32'hAB);
        chk("sb_mask", mask, 4'b1000);
        chk("sb_data", store_data, 32'hAB00_0000);
        chk("sb_mis", misalign, 1'b0);
        chk("sb_store", store_out, 1'b1);
        mem_op(1'b1, 3'b001, 32'h1000, 32'h1, 32'h0);
        chk("lh_mis", misalign, 1'b1);
        chk("lh_mask", mask, 4'b0000);
        chk("lh_we", we_out, 1'b0);
        chk("lh_sext", sign_ext, 1'b1);
        mem_op(1'b1, 3'b010, 32'h1000, 32'h4, 32'h0);
        chk("lw_mask", mask, 4'b1111);
        chk("lw_we", we_out, 1'b1);
        chk("lw_load", load_out, 1'b1);
        mem_op(1'b1, 3'b100, 32'h1000, 32'h2, 32'h0);
        chk("lbu_mask", mask, 4'b0100);
        chk("lbu_sext", sign_ext, 1'b0);
        mem_op(1'b0, 3'b001, 32'h1000, 32'h2, 32'h1234);
        chk("sh_mask", mask, 4'b1100);
        chk("sh_data", store_data, 32'h1234_0000);
        mem_op(1'b1, 3'b010, 32'h1000, 32'h2, 32'h0);
        chk("lw_mis", misalign, 1'b1);
        mem_op(1'b1, 3'b011, 32'h1000, 32'h0, 32'h0);
        chk("ld_mis", misalign, 1'b1);
        chk("ld_mask", mask, 4'b0000);

        // Backpressure: slot holds while out_ready is low
        in_valid = 1'b0; we = 1'b0;
        tick();
        chk("drain", out_valid, 1'b0);
        out_ready = 1'b0;
        set_op(4'd0, 32'd1, 32'd1);
        tick();
        chk("bp_first", alu, 32'd2);
        set_op(4'd0, 32'd10, 32'd10);
        for (int i = 0; i < 3; i++) begin
            chk("bp_ready", in_ready, 1'b0);
            tick();
            chk("bp_hold", alu, 32'd2);
            chk("bp_valid", out_valid, 1'b1);
            $display("bp    cycle %0d alu=%08h ready=%b", i, alu, in_ready);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release", in_ready, 1'b1);
        tick();
        chk("bp_second", alu, 32'd20);
        in_valid = 1'b0;
        tick();
        chk("bp_clear", out_valid, 1'b0);
        $display("bp    released alu=%08h valid=%b", alu, out_valid);

`ifdef EX_MULDIV_EN
        md_op("divu0", 3'd5, 32'd100,       32'd0,         32'hFFFF_FFFF);
        md_op("rem",   3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF);
        md_op("div",   3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD);
        md_op("divov", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        md_op("mul",   3'd0, 32'd6,         32'd7,         32'd42);
        md_op("mulh",  3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0);
        md_op("mulhu", 3'd3, 32'hFFFF_FFFF, 32'd2,         32'h1);

        // Reset during RUN aborts without producing a result
        begin
            logic seen;
            set_op(4'd0, 32'd9, 32'd3);
            md_sel = 1'b1; funct3 = 3'd5;
            tick();
            in_valid = 1'b0; md_sel = 1'b0;
            repeat (10) tick();
            rst = 1'b1;
            tick();
            chk("abort_busy", busy, 1'b0);
            chk("abort_valid", out_valid, 1'b0);
            rst = 1'b0;
            seen = 1'b0;
            repeat (40) begin
                tick();
                seen = seen | out_valid;
            end
            chk("abort_noresult", seen, 1'b0);
            $display("md    abort busy=%b valid=%b", busy, out_valid);
        end
`else
        // md_sel is ignored: executes as a plain ALU op with one-cycle latency
        set_op(4'd0, 32'd1, 32'd2);
        md_sel = 1'b1;
        tick();
        chk("md_ign_valid", out_valid, 1'b1);
        chk("md_ign", alu, 32'd3);
        chk("md_ign_busy", busy, 1'b0);
        $display("md    ignored alu=%08h busy=%b", alu, busy);
        in_valid = 1'b0; md_sel = 1'b0;
        tick();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
